// File: rtl/sync_arith_unit_4_core.sv
// -----------------------------------------------------------------------------
// sync_arith_unit_4_core
// Four-operation signed arithmetic/logic unit with registered result and
// status flags. All outputs update one rising edge after operand sampling.
//
// Operations (low 2 bits of i_op):
//   00 : A - 2*B (signed, range-checked)
//   01 : signed A < B, zero-extended
//   10 : A ^ B
//   11 : two's complement -> sign-magnitude conversion of A
//
// Ports:
//   i_clk     clock, rising edge
//   i_reset   synchronous active-high reset
//   i_arg_A   operand A, M bits, two's complement
//   i_arg_B   operand B, M bits, two's complement (unused by op 11)
//   i_op      opcode, N bits; bits above bit 1 must be zero
//   o_result  registered result, M bits
//   o_status  registered flags {ERR, PARITY, ONES, ZEROS}
//
// Build option:
//   SYNC_ARITH_SAT_EN  when defined, op 00 overflow saturates the result to
//                      the signed M-bit limit (ERR still set, other flags
//                      taken from the saturated value).
// -----------------------------------------------------------------------------
module sync_arith_unit_4_core #(
  parameter int unsigned N = 2,
  parameter int unsigned M = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  input  logic [N-1:0] i_op,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  localparam int unsigned WX = M + 2;

  localparam logic [1:0] OP_SUB2 = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_SM   = 2'b11;

  logic [M-1:0]  r_result;
  logic [3:0]    r_status;

  logic          w_op_illegal;
  logic [WX-1:0] w_a_ext;
  logic [WX-1:0] w_b2_ext;
  logic [WX-1:0] w_diff;
  logic          w_sub_ovf;
  logic [M-2:0]  w_abs;
  logic          w_a_min;
  logic [M-1:0]  w_res;
  logic          w_err;
  logic          w_sat;
  logic [M-1:0]  w_res_next;
  logic [3:0]    w_status_next;

  // Opcode bits above bit 1 only exist for N > 2.
  generate
    if (N > 2) begin : g_op_hi
      assign w_op_illegal = |i_op[N-1:2];
    end else begin : g_op_lo
      assign w_op_illegal = 1'b0;
    end
  endgenerate

  // A - 2*B at M+2 bits; fits in M bits iff the top three bits agree.
  assign w_a_ext   = {{2{i_arg_A[M-1]}}, i_arg_A};
  assign w_b2_ext  = {i_arg_B[M-1], i_arg_B, 1'b0};
  assign w_diff    = w_a_ext - w_b2_ext;
  assign w_sub_ovf = !((w_diff[WX-1] == w_diff[WX-2]) && (w_diff[WX-2] == w_diff[M-1]));

  // Magnitude of a negative A; the most-negative value has none.
  assign w_abs   = (~i_arg_A[M-2:0]) + (M-1)'(1);
  assign w_a_min = i_arg_A[M-1] && (i_arg_A[M-2:0] == '0);

  // Operation select and error detection.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    w_sat = 1'b0;
    unique case (i_op[1:0])
      OP_SUB2: begin
        w_res = w_diff[M-1:0];
        w_err = w_sub_ovf;
`ifdef SYNC_ARITH_SAT_EN
        w_sat = w_sub_ovf;
        if (w_sub_ovf) begin
          // Sign of the wide difference gives the overflow direction.
          w_res = w_diff[WX-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
        end
`endif
      end
      OP_SLT: begin
        w_res = M'($signed(i_arg_A) < $signed(i_arg_B));
      end
      OP_XOR: begin
        w_res = i_arg_A ^ i_arg_B;
      end
      OP_SM: begin
        w_res = i_arg_A[M-1] ? {1'b1, w_abs} : i_arg_A;
        w_err = w_a_min;
      end
      default: begin
        w_res = '0;
      end
    endcase
    if (w_op_illegal) begin
      w_err = 1'b1;
      w_sat = 1'b0;
    end
  end

  // Flag generation; a non-saturated error clears result and lower flags.
  always_comb begin
    w_res_next    = w_res;
    w_status_next = {w_err, ^w_res, &w_res, ~|w_res};
    if (w_err && !w_sat) begin
      w_res_next    = '0;
      w_status_next = 4'b1000;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result <= '0;
      r_status <= 4'b0000;
    end else begin
      r_result <= w_res_next;
      r_status <= w_status_next;
    end
  end

  assign o_result = r_result;
  assign o_status = r_status;

endmodule

// File: tb/tb_sync_arith_unit_4_core.sv
// -----------------------------------------------------------------------------
// Testbench for sync_arith_unit_4_core (N=2, M=4). Directed vectors are driven
// on the falling edge with their hand-computed responses queued; a monitor
// compares one queued response after every rising edge.
// -----------------------------------------------------------------------------
module tb_sync_arith_unit_4_core;

  logic       clk;
  logic       reset;
  logic [3:0] arg_a;
  logic [3:0] arg_b;
  logic [1:0] op;
  logic [3:0] result;
  logic [3:0] status;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         checks;
  int         errors;

  sync_arith_unit_4_core #(.N(2), .M(4)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_arg_A  (arg_a),
    .i_arg_B  (arg_b),
    .i_op     (op),
    .o_result (result),
    .o_status (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one response per rising edge once stimulus has been queued.
  initial begin
    logic [7:0] e;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({result, status} !== e) begin
          errors++;
          $display("FAIL %s: got result=%b status=%b, expected result=%b status=%b",
                   n, result, status, e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic drive(input string nm, input logic rst, input logic [1:0] o,
                       input int a, input int b,
                       input logic [3:0] er, input logic [3:0] es);
    @(negedge clk);
    reset = rst;
    op    = o;
    arg_a = 4'(a);
    arg_b = 4'(b);
    exp_q.push_back({er, es});
    name_q.push_back(nm);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    op     = 2'b10;
    arg_a  = 4'd5;
    arg_b  = 4'd3;

    // Reset held for three edges with arbitrary operands.
    drive("rst0", 1'b1, 2'b10, 5, 3, 4'b0000, 4'b0000);
    drive("rst1", 1'b1, 2'b00, 7, -1, 4'b0000, 4'b0000);
    drive("rst2", 1'b1, 2'b11, -8, 2, 4'b0000, 4'b0000);
    drive("first_sub", 1'b0, 2'b00, 3, 1, 4'b0001, 4'b0100);

    // op 00: A - 2B
    drive("sub_4_2",   1'b0, 2'b00, 4, 2,   4'b0000, 4'b0001);
    drive("sub_3_m1",  1'b0, 2'b00, 3, -1,  4'b0101, 4'b0000);
    drive("sub_4_3",   1'b0, 2'b00, 4, 3,   4'b1110, 4'b0100);
    drive("sub_m4_m2", 1'b0, 2'b00, -4, -2, 4'b0000, 4'b0001);
    drive("sub_7_2",   1'b0, 2'b00, 7, 2,   4'b0011, 4'b0000);
`ifdef SYNC_ARITH_SAT_EN
    drive("sub_ovf_pos", 1'b0, 2'b00, 7, -1, 4'b0111, 4'b1100);
    drive("sub_ovf_neg", 1'b0, 2'b00, -8, 1, 4'b1000, 4'b1100);
`else
    drive("sub_ovf_pos", 1'b0, 2'b00, 7, -1, 4'b0000, 4'b1000);
    drive("sub_ovf_neg", 1'b0, 2'b00, -8, 1, 4'b0000, 4'b1000);
`endif

    // op 01: signed less-than
    drive("slt_3_5",   1'b0, 2'b01, 3, 5,   4'b0001, 4'b0100);
    drive("slt_m4_3",  1'b0, 2'b01, -4, 3,  4'b0001, 4'b0100);
    drive("slt_m3_m3", 1'b0, 2'b01, -3, -3, 4'b0000, 4'b0001);
    drive("slt_4_m5",  1'b0, 2'b01, 4, -5,  4'b0000, 4'b0001);

    // op 10: xor
    drive("xor_2_3",   1'b0, 2'b10, 2, 3,  4'b0001, 4'b0100);
    drive("xor_5_10",  1'b0, 2'b10, 5, 10, 4'b1111, 4'b0010);

    // op 11: sign-magnitude (B should have no effect)
    drive("sm_m5", 1'b0, 2'b11, -5, 6,  4'b1101, 4'b0100);
    drive("sm_0",  1'b0, 2'b11, 0, -1,  4'b0000, 4'b0001);
    drive("sm_m7", 1'b0, 2'b11, -7, 0,  4'b1111, 4'b0010);
    drive("sm_3",  1'b0, 2'b11, 3, 5,   4'b0011, 4'b0000);
    drive("sm_m8", 1'b0, 2'b11, -8, 1,  4'b0000, 4'b1000);

    // Reset for a single edge between two computations.
    drive("mid_pre",  1'b0, 2'b00, 3, 1, 4'b0001, 4'b0100);
    drive("mid_rst",  1'b1, 2'b00, 4, 3, 4'b0000, 4'b0000);
    drive("mid_post", 1'b0, 2'b00, 4, 3, 4'b1110, 4'b0100);
    drive("mid_next", 1'b0, 2'b10, 2, 3, 4'b0001, 4'b0100);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
